audio_pwm_out: RTL

Downstream consumer of the volume-scaled 16-bit sample stream. Accepts signed samples over a valid/ready handshake into a one-entry holding buffer, converts each to an unsigned duty value, and drives a single-bit PWM audio pin. The new duty value is applied on each PWM period boundary. Sample underruns are detected and counted so the volume and sample path can be rate-checked.

---
 rtl/audio_pkg.sv | 20 ++
 rtl/audio_pwm_out_pwm_core.sv | 45 ++++
 rtl/audio_pwm_out.sv | 103 ++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared sample types and conversion helpers for the audio PWM path
package audio_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int PWM_BITS_DFLT = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Signed to offset-binary: flipping the MSB maps the most negative sample to zero.
    function automatic logic [SAMPLE_W-1:0] to_offset(input sample_t s);
        return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
    endfunction

    function automatic int midscale(input int bits);
        return 1 << (bits - 1);
    endfunction

    localparam int MIDSCALE = midscale(PWM_BITS_DFLT);

endpackage

// File: rtl/audio_pwm_out_pwm_core.sv
// rtl/audio_pwm_out_pwm_core.sv - free-running PWM counter, wrap detect and registered compare output
module pwm_core #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                wrap_o,
    output logic                pwm_o,
    output logic                period_start_o
);

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;
    logic                ps_q,  ps_d;

    assign wrap_o = en_i & (cnt_q == '1);

    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end
        pwm_d = en_i & (cnt_q < duty_i);
        // Registered from the wrap so it is high exactly while cnt reads zero.
        ps_d  = wrap_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
            ps_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
            ps_q  <= ps_d;
        end
    end

    assign pwm_o          = pwm_q;
    assign period_start_o = ps_q;

endmodule

// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - sample holding buffer, duty update on period wrap, underrun tracking
module audio_pwm_out #(
    parameter int SAMPLE_W = 16,
    parameter int PWM_BITS = 8,
    parameter int UCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                pwm_out,
    output logic                period_start,
    output logic                underrun,
    output logic [UCNT_W-1:0]   underrun_cnt
);

    import audio_pkg::*;

    localparam logic [PWM_BITS-1:0] MID = PWM_BITS'(midscale(PWM_BITS));

    logic [PWM_BITS-1:0] buf_q,  buf_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                buf_full_q, buf_full_d;
    logic                underrun_q, underrun_d;
    logic [UCNT_W-1:0]   ucnt_q, ucnt_d;

    logic                wrap;
    logic                accept;
    logic [SAMPLE_W-1:0] offset;
    logic [PWM_BITS-1:0] duty_in;
    logic                unused_lsbs;

    assign offset      = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0]};
    assign duty_in     = offset[SAMPLE_W-1 -: PWM_BITS];
    assign unused_lsbs = ^offset[SAMPLE_W-PWM_BITS-1:0];

    // Held low through reset so nothing is handed over while state is being cleared.
    assign sample_ready = rst_n & en & ~buf_full_q;
    assign accept       = sample_valid & sample_ready;

    always_comb begin
        buf_d      = buf_q;
        duty_d     = duty_q;
        buf_full_d = buf_full_q;
        underrun_d = 1'b0;
        ucnt_d     = ucnt_q;
        if (!en) begin
            duty_d     = MID;
            buf_full_d = 1'b0;
        end else begin
            if (wrap) begin
                if (buf_full_q) begin
                    duty_d     = buf_q;
                    buf_full_d = 1'b0;
                end else begin
                    underrun_d = 1'b1;
                    if (ucnt_q != '1) begin
                        ucnt_d = ucnt_q + UCNT_W'(1);
                    end
                end
            end
            // Ready is low whenever the buffer is full, so this never collides with a load.
            if (accept) begin
                buf_d      = duty_in;
                buf_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q      <= '0;
            duty_q     <= MID;
            buf_full_q <= 1'b0;
            underrun_q <= 1'b0;
            ucnt_q     <= '0;
        end else begin
            buf_q      <= buf_d;
            duty_q     <= duty_d;
            buf_full_q <= buf_full_d;
            underrun_q <= underrun_d;
            ucnt_q     <= ucnt_d;
        end
    end

    pwm_core #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm_core (
        .clk            (clk),
        .rst_n          (rst_n),
        .en_i           (en),
        .duty_i         (duty_q),
        .wrap_o         (wrap),
        .pwm_o          (pwm_out),
        .period_start_o (period_start)
    );

    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule
